fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Issues one instruction-memory request at a time for the current pc value and pulses the PC advance strobe (drives pc load) when memory grants the request.
- Queues returned instructions, each with its fetch address, in a small FIFO that feeds decode through a valid/ready handshake.
- Flush input discards queued and in-flight fetches after a redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 3, count width; equals log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- Async_reset  input  1  reset; synchronous, active-low, sampled on rising edge of clk.
- pc_in  input  32  current PC from the program counter.
- pc_load  output  1  advance strobe to the program counter (its load input).
- flush  input  1  redirect; pc_in already holds the target in this cycle.
- imem_req  output  1  memory request.
- imem_addr  output  32  request address.
- imem_gnt  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  response instruction word.
- inst_valid  output  1  FIFO head valid to decode.
- inst_ready  input  1  decode accepts head.
- inst_out  output  32  head instruction.
- inst_pc  output  32  head fetch address.
- count  output  CW  occupied entries.

Behaviour:
- Reset (Async_reset=0 at clock edge) has priority over everything.
  - State=IDLE; rd/wr pointers=0; count=0; req_pc=0; all storage=0.
  - Outputs: imem_req=0, pc_load=0, inst_valid=0, inst_out=0, inst_pc=0, count=0.
  - A response arriving after reset is ignored (IDLE ignores imem_rvalid).
- States: IDLE, REQ, WAIT, DROP.
- IDLE:
  - Go to REQ when !flush and count<DEPTH.
  - Space is reserved on entry: only this block pushes, so the slot cannot be taken.
- REQ:
  - imem_req = !flush (combinational). imem_addr = pc_in (combinational).
  - pc_load = imem_req & imem_gnt (combinational). This is the only source of pc_load; exactly one pulse per granted request.
  - On grant: req_pc <= pc_in, go to WAIT.
  - On flush: go to IDLE; no request and no pc_load that cycle.
  - Otherwise hold REQ; imem_addr tracks pc_in, which is stable while pc_load=0.
- WAIT:
  - On imem_rvalid with !flush: push {imem_rdata, req_pc}, go to IDLE.
  - On flush with imem_rvalid in the same cycle: discard data, go to IDLE.
  - On flush without imem_rvalid: go to DROP.
- DROP:
  - First imem_rvalid is discarded, then go to IDLE.
  - Further flushes in DROP keep DROP.
- imem_rvalid in IDLE or REQ: ignored.
- Minimum pc_load-to-pc_load spacing is 3 cycles with 1-cycle grant and response: REQ(gnt) -> WAIT(rvalid) -> IDLE -> REQ.
- FIFO:
  - inst_valid = (count!=0). inst_out and inst_pc are combinational from the rd pointer entry.
  - Pop when inst_valid & inst_ready. Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
  - Pop on empty is impossible (gated by inst_valid). Push on full is impossible (space reserved).
- Flush:
  - Next cycle count=0, pointers=0, inst_valid=0.
  - A pop in the flush cycle is still accepted by decode, but nothing is pushed.
  - Storage contents are not cleared.
- Width: all addresses are 32-bit. count is CW bits and never exceeds DEPTH.

Test Plan:
1. Reset with Async_reset=0 for 2 cycles, imem_rvalid=1 -> all outputs 0, count=0, no push, no pc_load.
2. pc_in=0x0, gnt and rvalid each 1 cycle after request, inst_ready=0 -> pc_load pulses every 3 cycles; after 4 fetches count=4 and imem_req stays 0; entries hold (rdata, pc) = (0x..,0x0),(..,0x4),(..,0x8),(..,0xC).
3. Full FIFO, inst_ready=1 for one cycle -> head pc 0x0 popped, count=3, new request issued for pc_in=0x10 the cycle after IDLE sees count<4.
4. Flush in WAIT, imem_rvalid 2 cycles later with rdata=0xDEADBEEF -> count=0 next cycle, DEADBEEF never appears on inst_out, next pc_load comes only after the DROP response.
5. Flush in same cycle as imem_rvalid and inst_ready=1 with count=2 -> head popped, response discarded, count=0 next cycle.
6. Flush in REQ with imem_gnt=1 -> imem_req=0 and pc_load=0 that cycle; next request uses redirect pc_in=0x100.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch stage sitting right after the program counter.
// Issues one instruction-memory request at a time, advances the PC on grant,
// and queues each returned word with its fetch address in a small FIFO for decode.
`timescale 1ns/1ps

module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          Async_reset,
    input  logic [31:0]   pc_in,
    output logic          pc_load,
    input  logic          flush,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst_out,
    output logic [31:0]   inst_pc,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [31:0]   req_pc;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          push;
    logic          pop;

    // State register; the reset name is historical, the reset itself is synchronous
    always_ff @(posedge clk) begin
        if (!Async_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE only starts a fetch when a FIFO slot is free, which reserves it
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!flush && (count_q < CW'(DEPTH))) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (imem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: request only in REQ, push only for an unflushed response in WAIT
    always_comb begin
        imem_req = 1'b0;
        push     = 1'b0;
        case (state)
            REQ:     imem_req = !flush;
            WAIT:    push     = imem_rvalid && !flush;
            default: begin
                imem_req = 1'b0;
                push     = 1'b0;
            end
        endcase
    end

    assign pc_load    = imem_req & imem_gnt;
    assign imem_addr  = pc_in;
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready;
    assign inst_out   = data_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];
    assign count      = count_q;

    // Remember the address of the granted request so the response can be tagged with it
    always_ff @(posedge clk) begin
        if (!Async_reset) begin
            req_pc <= '0;
        end else if (pc_load) begin
            req_pc <= pc_in;
        end
    end

    // FIFO pointers and occupancy; a flush empties the queue but a same-cycle pop still counts for decode
    always_ff @(posedge clk) begin
        if (!Async_reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // FIFO storage; cleared only by reset, a flush just abandons the old contents
    always_ff @(posedge clk) begin
        if (!Async_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed bench for fetch_buffer with a queue-based scoreboard.
// The main thread plays program counter and instruction memory; a monitor pops
// the expected queue whenever decode accepts a FIFO head.
`timescale 1ns/1ps

module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        Async_reset;
    logic [31:0] pc_in;
    logic        pc_load;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [$];

    logic        s_req;
    logic        s_pc_load;
    logic [31:0] s_addr;
    logic [2:0]  s_count;
    logic        s_valid;
    logic [31:0] s_out;
    logic [31:0] s_pcout;

    logic [31:0] rtab [4];
    logic [31:0] ptab [4];

    fetch_buffer #(.DEPTH(4), .CW(3)) dut (
        .clk         (clk),
        .Async_reset (Async_reset),
        .pc_in       (pc_in),
        .pc_load     (pc_load),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .count       (count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, sample outputs at the falling edge, then let the PC advance on pc_load
    task automatic applyStimulus(input logic f, input logic g, input logic rv,
                                 input logic [31:0] rd, input logic rdy);
        flush       = f;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        inst_ready  = rdy;
        @(negedge clk);
        s_req     = imem_req;
        s_pc_load = pc_load;
        s_addr    = imem_addr;
        s_count   = count;
        s_valid   = inst_valid;
        s_out     = inst_out;
        s_pcout   = inst_pc;
        @(posedge clk);
        #1;
        if (s_pc_load) pc_in = pc_in + 32'd4;
    endtask

    // REQ cycle with grant then WAIT cycle with response; caller records the expected entry
    task automatic fetchOne(input logic [31:0] rd, input logic [31:0] pc_exp);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("req_on_grant", {31'b0, s_req}, 32'd1);
        checkOutput("pc_load_on_grant", {31'b0, s_pc_load}, 32'd1);
        checkOutput("req_addr", s_addr, pc_exp);
        applyStimulus(1'b0, 1'b0, 1'b1, rd, 1'b0);
        checkOutput("wait_req", {31'b0, s_req}, 32'd0);
        checkOutput("wait_pc_load", {31'b0, s_pc_load}, 32'd0);
    endtask

    // Monitor: whenever decode takes the head, compare it against the oldest expected entry
    always @(negedge clk) begin
        if (Async_reset === 1'b1 && inst_valid === 1'b1) begin
            checks++;
            if (inst_out === 32'hDEADBEEF) begin
                errors++;
                $display("[TB] FAIL dropped_data actual=%h required=not DEADBEEF", inst_out);
            end
            if (inst_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pop_unexpected actual=%h/%h required=no entry", inst_out, inst_pc);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    checkOutput("pop_inst", inst_out, e[63:32]);
                    checkOutput("pop_pc", inst_pc, e[31:0]);
                end
            end
        end
    end

    initial begin
        rtab[0] = 32'h1111_1111; ptab[0] = 32'h0000_0000;
        rtab[1] = 32'h2222_2222; ptab[1] = 32'h0000_0004;
        rtab[2] = 32'h3333_3333; ptab[2] = 32'h0000_0008;
        rtab[3] = 32'h4444_4444; ptab[3] = 32'h0000_000C;

        pc_in       = 32'h0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;

        // 1. Reset for two cycles with a stray response present
        Async_reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hBAD0_0001, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hBAD0_0002, 1'b0);
        checkOutput("rst_req", {31'b0, s_req}, 32'd0);
        checkOutput("rst_pc_load", {31'b0, s_pc_load}, 32'd0);
        checkOutput("rst_valid", {31'b0, s_valid}, 32'd0);
        checkOutput("rst_inst_out", s_out, 32'd0);
        checkOutput("rst_inst_pc", s_pcout, 32'd0);
        checkOutput("rst_count", {29'b0, s_count}, 32'd0);
        Async_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        checkOutput("post_rst_count", {29'b0, s_count}, 32'd0);
        checkOutput("post_rst_valid", {31'b0, s_valid}, 32'd0);
        checkOutput("post_rst_req_no_gnt", {31'b0, s_req}, 32'd1);
        checkOutput("post_rst_no_pc_load", {31'b0, s_pc_load}, 32'd0);

        // 2. Four back-to-back fetches with decode stalled
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({rtab[i], ptab[i]});
            fetchOne(rtab[i], ptab[i]);
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("idle_req", {31'b0, s_req}, 32'd0);
            checkOutput("idle_pc_load", {31'b0, s_pc_load}, 32'd0);
            checkOutput("fill_count", {29'b0, s_count}, 32'(i + 1));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("full_no_req", {31'b0, s_req}, 32'd0);
        checkOutput("full_count", {29'b0, s_count}, 32'd4);

        // 3. One pop from a full FIFO opens a slot for pc 0x10
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("pop_full_count", {29'b0, s_count}, 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("after_pop_count", {29'b0, s_count}, 32'd3);
        checkOutput("after_pop_req", {31'b0, s_req}, 32'd0);
        exp_q.push_back({32'h5555_5555, 32'h0000_0010});
        fetchOne(32'h5555_5555, 32'h0000_0010);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("refill_count", {29'b0, s_count}, 32'd4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // 4. Flush in WAIT; the late response must be dropped
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_pc_load", {31'b0, s_pc_load}, 32'd1);
        checkOutput("t4_addr", s_addr, 32'h0000_0014);
        pc_in = 32'h0000_0200;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_pre_flush_count", {29'b0, s_count}, 32'd1);
        exp_q.delete();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_flushed_count", {29'b0, s_count}, 32'd0);
        checkOutput("t4_flushed_valid", {31'b0, s_valid}, 32'd0);
        checkOutput("t4_drop_req", {31'b0, s_req}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        checkOutput("t4_drop_pc_load", {31'b0, s_pc_load}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_no_push_count", {29'b0, s_count}, 32'd0);
        checkOutput("t4_idle_pc_load", {31'b0, s_pc_load}, 32'd0);
        exp_q.push_back({32'h6666_6666, 32'h0000_0200});
        fetchOne(32'h6666_6666, 32'h0000_0200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_count", {29'b0, s_count}, 32'd1);

        // 5. Flush together with response and a pop, two entries queued
        exp_q.push_back({32'h7777_7777, 32'h0000_0204});
        fetchOne(32'h7777_7777, 32'h0000_0204);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_count", {29'b0, s_count}, 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_addr", s_addr, 32'h0000_0208);
        pc_in = 32'h0000_0300;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8888_8888, 1'b1);
        checkOutput("t5_flush_cycle_count", {29'b0, s_count}, 32'd2);
        exp_q.delete();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_flushed_count", {29'b0, s_count}, 32'd0);
        checkOutput("t5_flushed_valid", {31'b0, s_valid}, 32'd0);

        // 6. Flush in REQ while memory grants; request restarts at the redirect target
        pc_in = 32'h0000_0100;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_flush_req", {31'b0, s_req}, 32'd0);
        checkOutput("t6_flush_pc_load", {31'b0, s_pc_load}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_idle_req", {31'b0, s_req}, 32'd0);
        exp_q.push_back({32'h9999_9999, 32'h0000_0100});
        fetchOne(32'h9999_9999, 32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t6_count", {29'b0, s_count}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_drained_count", {29'b0, s_count}, 32'd0);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
